prim_ram_1p_parity_retry: RTL and testbench

PRIM_RAM_1P_PARITY_RETRY -- requirements
Module: prim_ram_1p_parity_retry

---
 rtl/prim_ram_1p_parity_pkg.sv | 12 +
 rtl/prim_parity_gen.sv | 11 +
 rtl/prim_ram_1p_parity_retry.sv | 117 +++++++++++
 tb/tb_prim_ram_1p_parity_retry.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_ram_1p_parity_pkg.sv
// rtl/prim_ram_1p_parity_pkg.sv - shared types and constants for the parity-retry RAM wrapper
package prim_ram_1p_parity_pkg;

  localparam int ErrCntW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2
  } state_e;

endpackage

// File: rtl/prim_parity_gen.sv
// rtl/prim_parity_gen.sv - even parity bit over a data word (XOR reduction)
module prim_parity_gen #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/prim_ram_1p_parity_retry.sv
// rtl/prim_ram_1p_parity_retry.sv - single-port RAM front end with parity and one read retry
module prim_ram_1p_parity_retry
  import prim_ram_1p_parity_pkg::*;
#(
  parameter  int Width = 32,
  parameter  int Depth = 128,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic               write_i,
  input  logic [Aw-1:0]      addr_i,
  input  logic [Width-1:0]   wdata_i,
  output logic               rvalid_o,
  output logic [Width-1:0]   rdata_o,
  output logic               err_o,
  output logic [ErrCntW-1:0] err_cnt_o,
  output logic               ram_req_o,
  output logic               ram_write_o,
  output logic [Aw-1:0]      ram_addr_o,
  output logic [Width:0]     ram_wdata_o,
  output logic [Width:0]     ram_wmask_o,
  input  logic [Width:0]     ram_rdata_i
);

  state_e               state_q, state_d;
  logic [Aw-1:0]        addr_q, addr_d;
  logic [ErrCntW-1:0]   err_cnt_q;
  logic                 err_inc;
  logic                 wr_parity;
  logic                 rd_parity_bad;

  // Parity bit stored alongside the data so the full word XORs to zero.
  prim_parity_gen #(.Width(Width)) u_wr_parity (
    .data_i   (wdata_i),
    .parity_o (wr_parity)
  );

  // A nonzero XOR over the whole stored word means an odd number of flipped bits.
  prim_parity_gen #(.Width(Width + 1)) u_rd_check (
    .data_i   (ram_rdata_i),
    .parity_o (rd_parity_bad)
  );

  assign ram_wdata_o = {wr_parity, wdata_i};
  assign ram_wmask_o = '1;
  assign rdata_o     = ram_rdata_i[Width-1:0];
  assign err_cnt_o   = err_cnt_q;

  // State, retry address and saturating error counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (err_inc && (err_cnt_q != {ErrCntW{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  // Next-state, RAM strobes and response; everything is held quiet during reset.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    err_inc     = 1'b0;
    gnt_o       = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = addr_q;
    rvalid_o    = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          ram_req_o   = 1'b1;
          ram_write_o = write_i;
          ram_addr_o  = addr_i;
          if (!write_i) begin
            addr_d  = addr_i;
            state_d = RD1;
          end
        end
      end
      RD1: begin
        if (rd_parity_bad) begin
          err_inc   = 1'b1;
          ram_req_o = 1'b1;
          state_d   = RD2;
        end else begin
          rvalid_o = 1'b1;
          state_d  = IDLE;
        end
      end
      RD2: begin
        rvalid_o = 1'b1;
        err_o    = rd_parity_bad;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      gnt_o       = 1'b0;
      ram_req_o   = 1'b0;
      ram_write_o = 1'b0;
      rvalid_o    = 1'b0;
      err_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_prim_ram_1p_parity_retry.sv
// tb/tb_prim_ram_1p_parity_retry.sv - self-checking bench for the parity-retry RAM wrapper
module tb_prim_ram_1p_parity_retry;

  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic          write_i;
  logic [AW-1:0] addr_i;
  logic [W-1:0]  wdata_i;
  logic          rvalid_o;
  logic [W-1:0]  rdata_o;
  logic          err_o;
  logic [7:0]    err_cnt_o;
  logic          ram_req_o;
  logic          ram_write_o;
  logic [AW-1:0] ram_addr_o;
  logic [W:0]    ram_wdata_o;
  logic [W:0]    ram_wmask_o;
  logic [W:0]    ram_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    int         g;
    logic [W-1:0] d;
    logic       e;
    int         cnt;
  } exp_t;

  exp_t       sb[$];
  logic [W:0] inj[$];
  logic [W:0]   ram_mem   [D] = '{default: '0};
  logic [W-1:0] model_mem [D] = '{default: '0};
  int           model_cnt = 0;
  int           next_free = 0;
  int           last_lat  = 0;
  logic [W-1:0] last_d    = '0;
  logic         last_e    = 1'b0;

  prim_ram_1p_parity_retry #(.Width(W), .Depth(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o),
    .ram_req_o   (ram_req_o),
    .ram_write_o (ram_write_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wmask_o (ram_wmask_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [W:0] pop_inj();
    if (inj.size() == 0) return '0;
    return inj.pop_front();
  endfunction

  // External RAM with bit-flip injection: one queued flip mask is consumed per read.
  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_write_o)
        ram_mem[ram_addr_o] <= (ram_mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      else
        ram_rdata_i <= ram_mem[ram_addr_o] ^ pop_inj();
    end
  end

  // Per-cycle compare against the scoreboard of expected responses.
  always @(negedge clk) begin
    if (rst_i) begin
      chk("rst_gnt", gnt_o, 0);
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_ram_req", ram_req_o, 0);
      chk("rst_ram_write", ram_write_o, 0);
    end else begin
      bit exp_v;
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      chk("rvalid", rvalid_o, exp_v);
      if (!rvalid_o) chk("err_idle", err_o, 0);
      if (exp_v) begin
        if (rvalid_o) begin
          chk("rdata", rdata_o, sb[0].d);
          chk("err", err_o, sb[0].e);
          chk("err_cnt", err_cnt_o, sb[0].cnt);
          last_lat = cyc - sb[0].g;
          last_d   = rdata_o;
          last_e   = err_o;
        end
        void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [W:0] m1, input logic [W:0] m2);
    int expg;
    int n;
    logic [W:0] st;
    logic [W:0] r1;
    logic [W:0] r2;
    bit bad1;
    exp_t e;
    req_i   = 1'b1;
    write_i = wr;
    addr_i  = a;
    wdata_i = d;
    expg = (cyc > next_free) ? cyc : next_free;
    st   = {^model_mem[a], model_mem[a]};
    r1   = st ^ m1;
    r2   = st ^ m2;
    bad1 = ^r1;
    if (!wr) begin
      inj.push_back(m1);
      if (bad1) inj.push_back(m2);
    end
    n = 0;
    @(negedge clk);
    while (!gnt_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("grant_cycle", cyc, expg);
    if (gnt_o) begin
      if (wr) begin
        model_mem[a] = d;
        next_free = cyc + 1;
      end else begin
        e.g = cyc;
        if (!bad1) begin
          e.due = cyc + 1;
          e.d   = r1[W-1:0];
          e.e   = 1'b0;
          next_free = cyc + 2;
        end else begin
          model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
          e.due = cyc + 2;
          e.d   = r2[W-1:0];
          e.e   = ^r2;
          next_free = cyc + 3;
        end
        e.cnt = model_cnt;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sb.delete();
    inj.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    next_free = cyc;
  endtask

  function automatic logic [W:0] one_bit(input int b);
    logic [W:0] m;
    m    = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  initial begin
    rst_i   = 1'b1;
    req_i   = 1'b1;
    write_i = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_err_cnt", err_cnt_o, 0);
    rst_i = 1'b0;
    req_i = 1'b0;
    next_free = cyc;

    // Clean write then read.
    issue(1'b1, 7'd5, 32'h0000_00FF, '0, '0);
    issue(1'b0, 7'd5, '0, '0, '0);
    settle();
    chk("clean_data", last_d, 32'h0000_00FF);
    chk("clean_err", last_e, 0);
    chk("clean_lat", last_lat, 1);
    chk("clean_cnt", err_cnt_o, 0);

    // Single flip on the first read only: retry recovers.
    do_reset();
    issue(1'b0, 7'd5, '0, 33'h8, '0);
    settle();
    chk("retry_data", last_d, 32'h0000_00FF);
    chk("retry_err", last_e, 0);
    chk("retry_lat", last_lat, 2);
    chk("retry_cnt", err_cnt_o, 1);

    // Same bit flipped on both reads: uncorrectable.
    do_reset();
    issue(1'b0, 7'd5, '0, 33'h1, 33'h1);
    settle();
    chk("double_data", last_d, 32'h0000_00FE);
    chk("double_err", last_e, 1);
    chk("double_lat", last_lat, 2);
    chk("double_cnt", err_cnt_o, 1);

    // Counter saturation.
    for (int i = 0; i < 300; i++)
      issue(1'b0, AW'($urandom_range(0, D - 1)), '0, one_bit($urandom_range(0, W)), '0);
    settle();
    chk("sat_cnt", err_cnt_o, 255);

    // Reset while the first read is outstanding.
    req_i   = 1'b1;
    write_i = 1'b0;
    addr_i  = 7'd5;
    inj.push_back('0);
    @(negedge clk);
    chk("midrst_grant", gnt_o, 1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    chk("midrst_gnt_low", gnt_o, 0);
    @(posedge clk);
    #1;
    inj.delete();
    rst_i = 1'b0;
    req_i = 1'b0;
    next_free = cyc;
    chk("midrst_cnt", err_cnt_o, 0);
    last_lat = 0;
    issue(1'b0, 7'd5, '0, '0, '0);
    settle();
    chk("midrst_data", last_d, 32'h0000_00FF);
    chk("midrst_lat", last_lat, 1);

    // Randomized back-to-back traffic with occasional idle gaps.
    for (int i = 0; i < 500; i++) begin
      int sel;
      int b;
      logic [W:0] m1;
      logic [W:0] m2;
      sel = $urandom_range(0, 3);
      b   = $urandom_range(0, W);
      m1  = (sel == 1 || sel == 2) ? one_bit(b) : '0;
      m2  = (sel == 2) ? one_bit($urandom_range(0, W)) : '0;
      issue($urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), $urandom, m1, m2);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    settle();
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
